// File: rtl/blkarb_if.sv
// blkarb_if: source-side give/have/din and output-side dout/ofull bundle for blkarb.
// master = arbiter side, slave = sources/FIFO/bench side.
interface blkarb_if #(
   parameter int NSRC  = 17,
   parameter int SBITS = 5
);
   logic                 enable;
   logic [NSRC-1:0]      have;
   logic [NSRC-1:0]      give;
   logic [16*NSRC-1:0]   din;
   logic                 ofull;
   logic [15:0]          dout;
   logic                 dout_vld;
   logic                 busy;
   logic [SBITS-1:0]     cur_src;
   logic                 hdr_err;

   modport master (
      input  enable, have, din, ofull,
      output give, dout, dout_vld, busy, cur_src, hdr_err
   );

   modport slave (
      output enable, have, din, ofull,
      input  give, dout, dout_vld, busy, cur_src, hdr_err
   );
endinterface

// File: rtl/blkarb.sv
// blkarb: round-robin block readout arbiter; one whole header-sized block per grant.
// Optional build macro BLKARB_HISTPRIO_EN gives source NSRC-1 absolute priority.
module blkarb #(
   parameter int NSRC  = 17,
   parameter int SBITS = 5
) (
   input  logic     clk,
   input  logic     rst_n,
   blkarb_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HREQ = 3'd1,
      ST_HCAP = 3'd2,
      ST_BODY = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t           state_r, state_s;
   logic [SBITS-1:0] cur_src_r, cur_src_s;
   logic [SBITS-1:0] last_r, last_s;
   logic [8:0]       cnt_r, cnt_s;
   logic             hdr_err_r, hdr_err_s;
   logic             hist_r, hist_s;
   logic             dout_vld_r;
   logic [NSRC-1:0]  give_s;
   logic             pick_vld_s;
   logic [SBITS-1:0] pick_s;
   logic             pick_hist_s;
   logic [15:0]      word_s;
   logic [8:0]       len_s;

   function automatic logic [15:0] src_word(input logic [16*NSRC-1:0] d,
                                            input logic [SBITS-1:0]   sel);
      logic [15:0] w;
      w = 16'h0000;
      for (int i = 0; i < NSRC; i++) begin
         if (sel == SBITS'(i)) begin
            w = d[16*i +: 16];
         end
      end
      return w;
   endfunction

   // A header without the marker bit is read as an empty block.
   function automatic logic [8:0] hdr_len(input logic mark, input logic [8:0] len);
      return mark ? len : 9'd0;
   endfunction

   // Nearest requester after 'last', wrapping; 'last' itself has lowest priority.
   function automatic logic [SBITS:0] rr_pick(input logic [NSRC-1:0]  req,
                                              input logic [SBITS-1:0] last);
      logic [SBITS:0]   res;
      logic [SBITS-1:0] idx;
      res = {1'b0, {SBITS{1'b0}}};
      for (int k = NSRC; k >= 1; k--) begin
         if (int'(last) + k >= NSRC) begin
            idx = SBITS'(int'(last) + k - NSRC);
         end else begin
            idx = SBITS'(int'(last) + k);
         end
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign word_s = src_word(bus.din, cur_src_r);
   assign len_s  = hdr_len(word_s[15], word_s[8:0]);

   // Requester selection for the next grant
   always_comb begin
      pick_hist_s            = 1'b0;
      {pick_vld_s, pick_s}   = rr_pick(bus.have, last_r);
`ifdef BLKARB_HISTPRIO_EN
      if (bus.have[NSRC-1]) begin
         pick_vld_s  = 1'b1;
         pick_s      = SBITS'(NSRC-1);
         pick_hist_s = 1'b1;
      end else begin
         pick_hist_s = 1'b0;
      end
`endif
   end

   // Next-state and give generation; give is gated directly by ofull
   always_comb begin
      state_s   = state_r;
      cur_src_s = cur_src_r;
      last_s    = last_r;
      cnt_s     = cnt_r;
      hdr_err_s = hdr_err_r;
      hist_s    = hist_r;
      give_s    = {NSRC{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (bus.enable && pick_vld_s) begin
               cur_src_s = pick_s;
               hist_s    = pick_hist_s;
               state_s   = ST_HREQ;
            end else begin
               state_s   = ST_IDLE;
            end
         end
         ST_HREQ: begin
            if (!bus.ofull) begin
               give_s[cur_src_r] = 1'b1;
               state_s           = ST_HCAP;
            end else begin
               state_s           = ST_HREQ;
            end
         end
         ST_HCAP: begin
            if (!word_s[15]) begin
               hdr_err_s = 1'b1;
            end else begin
               hdr_err_s = hdr_err_r;
            end
            cnt_s = len_s;
            if (len_s == 9'd0) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_BODY;
            end
         end
         ST_BODY: begin
            if (cnt_r == 9'd0) begin
               state_s = ST_DONE;
            end else if (!bus.ofull) begin
               give_s[cur_src_r] = 1'b1;
               cnt_s             = cnt_r - 9'd1;
               if (cnt_r == 9'd1) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_BODY;
               end
            end else begin
               state_s = ST_BODY;
            end
         end
         ST_DONE: begin
            // A priority-served history block leaves the round-robin pointer alone.
            if (!hist_r) begin
               last_s = cur_src_r;
            end else begin
               last_s = last_r;
            end
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cur_src_r  <= {SBITS{1'b0}};
         last_r     <= SBITS'(NSRC-1);
         cnt_r      <= 9'd0;
         hdr_err_r  <= 1'b0;
         hist_r     <= 1'b0;
         dout_vld_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         cur_src_r  <= cur_src_s;
         last_r     <= last_s;
         cnt_r      <= cnt_s;
         hdr_err_r  <= hdr_err_s;
         hist_r     <= hist_s;
         dout_vld_r <= |give_s;
      end
   end

   // The source registers din on give, so dout is its word qualified by the delayed strobe.
   assign bus.give     = give_s;
   assign bus.dout     = dout_vld_r ? word_s : 16'h0000;
   assign bus.dout_vld = dout_vld_r;
   assign bus.busy     = (state_r != ST_IDLE);
   assign bus.cur_src  = cur_src_r;
   assign bus.hdr_err  = hdr_err_r;

endmodule

// File: tb/tb_blkarb.sv
// tb_blkarb: directed bench for blkarb with per-source block memories and an output log.
module tb_blkarb;
   localparam int NSRC  = 17;
   localparam int SBITS = 5;

   logic clk = 1'b0;
   logic rst_n;

   blkarb_if #(.NSRC(NSRC), .SBITS(SBITS)) bus ();

   blkarb #(.NSRC(NSRC), .SBITS(SBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [NSRC][1024];
   int          wr_len [NSRC];
   int          rd_ptr [NSRC];
   logic [15:0] src_q [NSRC];

   logic [15:0] out_q [$];
   logic [4:0]  grant_q [$];
   logic        busy_d = 1'b0;
   int          give_ofull_cnt = 0;
   int          vld_ofull_cnt = 0;

   int checks = 0;
   int failures = 0;

   // Source model: word appears on din the cycle after give
   always @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (!rst_n) begin
            src_q[i] <= 16'h0000;
         end else if (bus.give[i]) begin
            src_q[i]  <= mem[i][rd_ptr[i]];
            rd_ptr[i] <= rd_ptr[i] + 1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         bus.have[i]          = (rd_ptr[i] < wr_len[i]);
         bus.din[16*i +: 16]  = src_q[i];
      end
   end

   // Output/grant log
   always @(negedge clk) begin
      if (bus.dout_vld) out_q.push_back(bus.dout);
      if (bus.busy && !busy_d) grant_q.push_back(bus.cur_src);
      busy_d <= bus.busy;
      if (bus.ofull && (|bus.give)) give_ofull_cnt <= give_ofull_cnt + 1;
      if (bus.ofull && bus.dout_vld) vld_ofull_cnt <= vld_ofull_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int base, input logic [15:0] ex [$]);
      chk({tag, "_count"}, out_q.size() - base, ex.size());
      for (int k = 0; k < ex.size(); k++) begin
         chk(tag, (base + k < out_q.size()) ? {16'h0000, out_q[base + k]} : 32'h0000DEAD,
             {16'h0000, ex[k]});
      end
   endtask

   task automatic load_blk(input int s, input logic [15:0] hdr, input int nbody,
                           input logic [15:0] base);
      mem[s][wr_len[s]] = hdr;
      for (int k = 0; k < nbody; k++) mem[s][wr_len[s] + 1 + k] = base + 16'(k);
      wr_len[s] = wr_len[s] + 1 + nbody;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_quiet(input int budget);
      int n;
      int quiet;
      n = 0;
      quiet = 0;
      while (quiet < 3 && n < budget) begin
         @(negedge clk);
         n++;
         if (bus.busy || bus.dout_vld || (bus.have != '0)) quiet = 0;
         else quiet++;
      end
      chk("timeout", 32'(quiet < 3), 32'd0);
   endtask

   logic        exp_g [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic        exp_v [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [15:0] exp_d [7] = '{16'h0000, 16'h0000, 16'h8002, 16'h0000, 16'h1111, 16'h2222, 16'h0000};
   logic        exp_b [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      logic [15:0] ex [$];
      int ob;
      int gb;
      int d0;
      int d1;
      int bad;

      rst_n      = 1'b0;
      bus.enable = 1'b0;
      bus.ofull  = 1'b0;
      for (int i = 0; i < NSRC; i++) wr_len[i] = 0;

      // reset values
      @(posedge clk);
      @(negedge clk);
      chk("rst_give", 32'(bus.give), 32'd0);
      chk("rst_outs", {bus.dout, 3'b000, bus.dout_vld, bus.busy, bus.hdr_err, 3'b000, bus.cur_src},
          32'd0);
      tick();
      rst_n      = 1'b1;
      bus.enable = 1'b1;
      tick();

      // round robin from reset: 0, 5, 16 each LEN=1, then a second block on 0
      ob = out_q.size();
      gb = grant_q.size();
      load_blk(0, 16'h8001, 1, 16'hA001);
      load_blk(5, 16'h8001, 1, 16'hA501);
      load_blk(16, 16'h8001, 1, 16'hB001);
      load_blk(0, 16'h8001, 1, 16'hA002);
      wait_quiet(200);
      chk("rr_ngrant", grant_q.size() - gb, 32'd4);
`ifdef BLKARB_HISTPRIO_EN
      chk("rr_g0", 32'(grant_q[gb]), 32'd16);
      chk("rr_g1", 32'(grant_q[gb + 1]), 32'd0);
      chk("rr_g2", 32'(grant_q[gb + 2]), 32'd5);
      chk("rr_g3", 32'(grant_q[gb + 3]), 32'd0);
      ex = '{16'h8001, 16'hB001, 16'h8001, 16'hA001, 16'h8001, 16'hA501, 16'h8001, 16'hA002};
`else
      chk("rr_g0", 32'(grant_q[gb]), 32'd0);
      chk("rr_g1", 32'(grant_q[gb + 1]), 32'd5);
      chk("rr_g2", 32'(grant_q[gb + 2]), 32'd16);
      chk("rr_g3", 32'(grant_q[gb + 3]), 32'd0);
      ex = '{16'h8001, 16'hA001, 16'h8001, 16'hA501, 16'h8001, 16'hB001, 16'h8001, 16'hA002};
`endif
      chk_out("rr_data", ob, ex);

      // single block on source 3: cycle-exact give/dout/busy
      tick();
      load_blk(3, 16'h8002, 0, 16'h0000);
      mem[3][wr_len[3]]     = 16'h1111;
      mem[3][wr_len[3] + 1] = 16'h2222;
      wr_len[3] = wr_len[3] + 2;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk($sformatf("single_c%0d", c), {13'd0, bus.give[3], bus.dout_vld, bus.dout, bus.busy},
             {13'd0, exp_g[c], exp_v[c], exp_d[c], exp_b[c]});
         if (c == 1) chk("single_src", 32'(bus.cur_src), 32'd3);
      end
      wait_quiet(50);

      // backpressure: LEN=10 on source 7, ofull high for cycles 5..8
      ob = out_q.size();
      d0 = give_ofull_cnt;
      d1 = vld_ofull_cnt;
      tick();
      load_blk(7, 16'h800A, 10, 16'h7000);
      repeat (5) @(posedge clk);
      #1 bus.ofull = 1'b1;
      repeat (4) @(posedge clk);
      #1 bus.ofull = 1'b0;
      wait_quiet(100);
      chk("bp_give_ofull", give_ofull_cnt - d0, 32'd0);
      chk("bp_vld_ofull", vld_ofull_cnt - d1, 32'd1);
      ex = '{16'h800A};
      for (int k = 0; k < 10; k++) ex.push_back(16'h7000 + 16'(k));
      chk_out("bp_data", ob, ex);

      // LEN = 0
      ob = out_q.size();
      tick();
      load_blk(9, 16'h8000, 0, 16'h0000);
      wait_quiet(50);
      ex = '{16'h8000};
      chk_out("len0", ob, ex);

      // LEN = 511: 512 words total
      ob = out_q.size();
      tick();
      load_blk(2, 16'h81FF, 511, 16'h5A00);
      wait_quiet(800);
      chk("len511_count", out_q.size() - ob, 32'd512);
      bad = 0;
      for (int k = 0; k < 512; k++) begin
         if (ob + k >= out_q.size()) bad++;
         else if (out_q[ob + k] !== ((k == 0) ? 16'h81FF : 16'h5A00 + 16'(k - 1))) bad++;
      end
      chk("len511_words_bad", bad, 32'd0);
      chk("hdr_err_clean", 32'(bus.hdr_err), 32'd0);

      // bad header on 4, normal block on 6 behind it
      ob = out_q.size();
      tick();
      load_blk(4, 16'h0005, 0, 16'h0000);
      load_blk(6, 16'h8001, 1, 16'hC601);
      wait_quiet(100);
      chk("hdr_err_set", 32'(bus.hdr_err), 32'd1);
      ex = '{16'h0005, 16'h8001, 16'hC601};
      chk_out("bad_hdr", ob, ex);
      repeat (3) @(negedge clk);
      chk("hdr_err_sticky", 32'(bus.hdr_err), 32'd1);

      // reset mid-body on source 11
      tick();
      load_blk(11, 16'h8014, 20, 16'hBB00);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_give_before_edge", 32'(bus.give[11]), 32'd1);
      @(negedge clk);
      chk("rst_mid_give", 32'(bus.give), 32'd0);
      chk("rst_mid_outs", {bus.dout, 3'b000, bus.dout_vld, bus.busy, bus.hdr_err, 3'b000, bus.cur_src},
          32'd0);
      for (int i = 0; i < NSRC; i++) wr_len[i] = rd_ptr[i];
      tick();
      rst_n = 1'b1;
      tick();
      gb = grant_q.size();
      load_blk(12, 16'h8001, 1, 16'hCC01);
      load_blk(0, 16'h8001, 1, 16'hC001);
      wait_quiet(100);
      chk("rst_ngrant", grant_q.size() - gb, 32'd2);
      chk("rst_first_grant", (grant_q.size() > gb) ? 32'(grant_q[gb]) : 32'hFF, 32'd0);
      chk("rst_second_grant", (grant_q.size() > gb + 1) ? 32'(grant_q[gb + 1]) : 32'hFF, 32'd12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
